// File: rtl/mem_responder_if.sv
// Memory request/response bus between the CPU datapath and the memory responder.
// The master drives requests (address from MAR, write data from MDR); the slave
// answers with read data, a completion pulse and a busy flag.
interface mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] Mdatain;
    logic              Done;
    logic              Busy;

    modport master (
        output Read, Write, address, data_in,
        input  Mdatain, Done, Busy
    );

    modport slave (
        input  Read, Write, address, data_in,
        output Mdatain, Done, Busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed synchronous memory acting as the responding end of the CPU
// memory interface. A request is accepted on the rising edge of Read|Write
// while idle, completes after LATENCY cycles with a one-cycle Done pulse, and
// read data is held on Mdatain until the next read completes or clear.
module mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic           clock,
    input  logic           clear,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                req_prev_q, req_prev_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                op_write_q, op_write_d;
    logic [DATA_W-1:0]   mdatain_q, mdatain_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                mem_we;
    logic                req;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    assign req = bus.Read | bus.Write;

    // Next-state logic: edge-detect new requests in idle, count down the access latency, then pulse Done for one cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_prev_d = req;
        addr_d     = addr_q;
        data_d     = data_q;
        op_write_d = op_write_q;
        mdatain_d  = mdatain_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req && !req_prev_q) begin
                    state_d    = S_WAIT;
                    cnt_d      = CNT_LOAD;
                    addr_d     = bus.address;
                    data_d     = bus.data_in;
                    op_write_d = bus.Write;
                    busy_d     = 1'b1;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    mem_we  = op_write_q;
                    if (!op_write_q) begin
                        mdatain_d = mem[addr_q];
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and data registers; clear aborts any access in flight
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            req_prev_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            op_write_q <= 1'b0;
            mdatain_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_prev_q <= req_prev_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_write_q <= op_write_d;
            mdatain_q  <= mdatain_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array keeps its contents through clear; a write aborted by clear never commits
    always_ff @(posedge clock) begin
        if (!clear && mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.Mdatain = mdatain_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = busy_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synchronous word-addressed memory that is the responding end of the CPU's memory interface.
- Accepts read and write requests issued by the datapath/control path: the address from MAR, write data from MDR.
- For reads, returns data on Mdatain for loading into MDR, after a fixed, programmable access latency.
- Signals completion with a one-cycle Done pulse, so the control unit can stall in wait states.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 9, address width; array depth is 2**ADDR_W words
- LATENCY, 2, cycles from request acceptance to Done; legal range 1..15

Ports:
- clock  in  1  system clock, all state changes on rising edge
- clear  in  1  reset, synchronous, active-high
- Read  in  1  read request (level)
- Write  in  1  write request (level)
- address  in  ADDR_W  word address, MAR low bits
- data_in  in  DATA_W  write data, MDR output
- Mdatain  out  DATA_W  read data to MDR
- Done  out  1  one-cycle completion pulse
- Busy  out  1  high while an access is in flight

Behaviour:
- Interface: one clock (clock); reset clear is synchronous and active-high.
- Reset (clear high at a rising edge):
  - state goes to IDLE; Mdatain=0, Done=0, Busy=0, wait counter=0, req_prev=0.
  - Memory array contents are NOT cleared.
  - clear has priority over every other event and aborts any in-flight access; an aborted write does not modify the array.
- Request detection:
  - req = Read | Write; req_prev is registered req.
  - A new access is accepted only in IDLE, on an edge where req=1 and req_prev=0 (rising-edge detect).
  - Holding Read/Write high across Done does not start a second access; the request must drop for at least one cycle.
  - Because req_prev resets to 0, a request held high through clear is accepted on the first edge after clear drops.
- Capture on acceptance: address, data_in and op latched; Write has priority, so Read=Write=1 is a write.
- States:
  - IDLE: Busy=0; on acceptance go to WAIT, counter = LATENCY-1, Busy=1 from the next cycle.
  - WAIT: counter decrements each edge. At the edge where counter=0:
    - write op: array[addr_lat] <= data_lat.
    - read op: Mdatain <= array[addr_lat].
    - Done <= 1, Busy <= 0, go to RESP.
    - With LATENCY=1, WAIT lasts one cycle.
  - RESP: Done high for exactly this one cycle; next edge Done <= 0, go to IDLE. A request rising in the RESP cycle is not accepted. Requests are never queued.
- Latency: acceptance at edge k gives Done high in the cycle following edge k+LATENCY; Mdatain valid from that same edge.
- Mdatain holds the last read value until the next read completes or clear. Writes never change Mdatain.
- Inputs change during WAIT: ignored, since latched copies are used.
- Read-after-write to the same address returns the new data, because the write commits before the next access can be accepted.
- Address wraps naturally; no out-of-range case exists.

Test Plan:
- Reset: hold clear 2 cycles with Read=1 -> Mdatain=0, Done=0, Busy=0. Read is then accepted on the first edge after clear drops, and Done pulses LATENCY edges later.
- Write then read, LATENCY=2: write 0x0000_00A5 to addr 0x012 -> Done 2 cycles after acceptance, Mdatain unchanged (0). Drop Write, then read 0x012 -> Done after 2 cycles, Mdatain=0x0000_00A5 and held afterward.
- Held request: keep Read high for 8 cycles at addr 0x012 -> exactly one Done pulse; Busy high only during WAIT.
- Simultaneous Read=Write=1 with data 0xDEAD_BEEF at addr 0x1FF -> treated as write, Mdatain unchanged. A subsequent read of 0x1FF returns 0xDEAD_BEEF; also verify wrap using address 0x000 (distinct from 0x1FF).
- Abort: accept a write of 0x1234_5678 to addr 0x005 (prior content 0x0), assert clear during WAIT -> Done never pulses, state returns to IDLE. A later read of 0x005 returns 0x0.
- LATENCY=1 build: read accepted at edge k -> Done in the cycle after edge k+1. Back-to-back reads of addr 3 then 4, with one low cycle between requests, return their respective stored values.
